// File: rtl/opti_out_stage.sv
// opti_out_stage: output conditioning after the SOS IIR cascade.
// A Q2.14 gain is applied with round-half-up and saturation, and results are
// buffered in a small FIFO that the consumer drains by ready/valid.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   data_in, data_valid_in     24-bit signed sample and its one-cycle strobe
//   gain                       signed Q2.14 gain, sampled with each strobe
//   clr_flags                  pulse clearing the sticky flags
//   m_data, m_valid, m_ready   FIFO head (0 when empty), non-empty, consumer accept
//   level                      FIFO occupancy 0..DEPTH
//   sat_flag, ovf_flag         sticky: result clipped / sample dropped on full
module opti_out_stage #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned GAIN_W = 16,
   parameter int unsigned FRAC   = 14
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic signed [23:0]         data_in,
   input  logic                       data_valid_in,
   input  logic signed [GAIN_W-1:0]   gain,
   input  logic                       clr_flags,
   output logic signed [23:0]         m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       sat_flag,
   output logic                       ovf_flag
);

   localparam int unsigned DW = 24;
   localparam int unsigned PW = DW + GAIN_W;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   localparam logic signed [PW-1:0] RND     = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   logic signed [PW-1:0] p1_q, p1_d;
   logic                 v1_q;

   logic signed [PW-1:0] rnd_sum, shifted;
   logic                 clip_hi, clip_lo;
   logic signed [DW-1:0] r_sat;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          m_valid_q, m_valid_d;
   logic [DW-1:0] m_data_q, m_data_d;
   logic          sat_q, sat_d, ovf_q, ovf_d;
   logic          full, push, pop, drop;

   // Stage 1: full-precision product
   assign p1_d = PW'(data_in) * PW'(gain);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_q <= '0;
         v1_q <= 1'b0;
      end else begin
         v1_q <= data_valid_in;
         if (data_valid_in) p1_q <= p1_d;
      end
   end

   // Stage 2: round half toward +inf, then clip to 24-bit signed range
   always_comb begin
      rnd_sum = p1_q + RND;
      shifted = rnd_sum >>> FRAC;
      clip_hi = shifted > SAT_MAX;
      clip_lo = shifted < SAT_MIN;
      r_sat   = shifted[DW-1:0];
      if (clip_hi) r_sat = SAT_MAX[DW-1:0];
      if (clip_lo) r_sat = SAT_MIN[DW-1:0];
   end

   // FIFO control; the head is pre-computed so m_data/m_valid come from flops
   always_comb begin
      full      = (level_q == LW'(DEPTH));
      pop       = m_valid_q & m_ready;
      push      = v1_q & (~full | pop);
      drop      = v1_q & full & ~pop;
      wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d   = level_q;
      if (push && !pop) level_d = level_q + LW'(1);
      if (pop && !push) level_d = level_q - LW'(1);
      m_valid_d = (level_d != '0);
      m_data_d  = '0;
      if (m_valid_d) begin
         // Slot being written this cycle becomes the head only when it is the next read slot
         if (push && (wr_ptr_q == rd_ptr_d)) m_data_d = r_sat;
         else                                m_data_d = mem[rd_ptr_d];
      end
      sat_d = (v1_q & (clip_hi | clip_lo)) | (sat_q & ~clr_flags);
      ovf_d = drop | (ovf_q & ~clr_flags);
   end

   // Storage array: no reset, occupancy is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= r_sat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         sat_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         sat_q     <= sat_d;
         ovf_q     <= ovf_d;
      end
   end

   assign m_data   = m_data_q;
   assign m_valid  = m_valid_q;
   assign level    = level_q;
   assign sat_flag = sat_q;
   assign ovf_flag = ovf_q;

endmodule

// File: tb/tb_opti_out_stage.sv
// Scoreboard bench for opti_out_stage: directed samples push hand-computed
// results into a queue; a monitor pops and compares on every handshake.
module tb_opti_out_stage;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [23:0] data_in = '0;
   logic               data_valid_in = 1'b0;
   logic signed [15:0] gain = '0;
   logic               clr_flags = 1'b0;
   logic signed [23:0] m_data;
   logic               m_valid;
   logic               m_ready = 1'b0;
   logic [3:0]         level;
   logic               sat_flag, ovf_flag;

   int n_cmp = 0;
   int n_bad = 0;
   logic [23:0] exp_q [$];

   opti_out_stage #(.DEPTH(8), .GAIN_W(16), .FRAC(14)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid_in(data_valid_in),
      .gain(gain), .clr_flags(clr_flags), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .level(level), .sat_flag(sat_flag), .ovf_flag(ovf_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [23:0] got, input logic [23:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h @%0t", name, got, want, $time);
      end
   endtask

   // Monitor: every accepted head must match the oldest expected sample
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got %h expected none @%0t", m_data, $time);
         end else begin
            chk("sb_data", m_data, exp_q.pop_front());
         end
      end
   end

   // One strobe; called right after a rising edge, returns #1 after the capturing edge
   task automatic send(input logic [23:0] d, input logic [15:0] g, input logic [23:0] e,
                       input bit kept);
      data_in       = d;
      gain          = g;
      data_valid_in = 1'b1;
      if (kept) exp_q.push_back(e);
      @(posedge clk); #1;
      data_valid_in = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      cyc(1);
      clr_flags = 1'b0;
   endtask

   task automatic drain(input string name);
      int k;
      m_ready = 1'b1;
      k = 0;
      while (level != 0 && k < 50) begin cyc(1); k++; end
      n_cmp++;
      if (k >= 50) begin
         n_bad++;
         $display("FAIL %s_timeout: level %0d expected 0", name, level);
      end
      cyc(1);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_valid", 24'(m_valid), 24'd0);
      chk("rst_level", 24'(level), 24'd0);
      chk("rst_data", m_data, 24'd0);
      chk("rst_sat", 24'(sat_flag), 24'd0);
      chk("rst_ovf", 24'(ovf_flag), 24'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Unity gain, 2-edge latency, single-cycle valid
      m_ready = 1'b1;
      send(24'h123456, 16'h4000, 24'h123456, 1'b1);
      chk("lat_e0_valid", 24'(m_valid), 24'd0);
      cyc(1);
      chk("lat_e1_valid", 24'(m_valid), 24'd1);
      chk("lat_e1_data", m_data, 24'h123456);
      cyc(1);
      chk("lat_e2_valid", 24'(m_valid), 24'd0);
      chk("unity_sat", 24'(sat_flag), 24'd0);

      // Half gain rounding: 3*0.5=1.5->2, -3*0.5=-1.5->-1
      send(24'd3, 16'h2000, 24'd2, 1'b1);
      send(24'hFFFFFD, 16'h2000, 24'hFFFFFF, 1'b1);
      cyc(3);
      chk("round_sat", 24'(sat_flag), 24'd0);

      // Positive clip
      send(24'h7FFFFF, 16'h7FFF, 24'h7FFFFF, 1'b1);
      cyc(2);
      chk("clip_pos_sat", 24'(sat_flag), 24'd1);
      pulse_clr();
      cyc(1);
      chk("clr_sat", 24'(sat_flag), 24'd0);

      // -full scale * -2.0 clips to +max
      send(24'h800000, 16'h8000, 24'h7FFFFF, 1'b1);
      cyc(2);
      chk("clip_neg2_sat", 24'(sat_flag), 24'd1);
      pulse_clr();

      // Negative clip: -full scale * ~2.0
      send(24'h800000, 16'h7FFF, 24'h800000, 1'b1);
      cyc(2);
      chk("clip_neg_sat", 24'(sat_flag), 24'd1);
      pulse_clr();
      cyc(1);

      // Overflow: 9 pushes into depth 8 with consumer stalled
      m_ready = 1'b0;
      for (int i = 1; i <= 9; i++) send(24'(i), 16'h4000, 24'(i), i <= 8);
      cyc(2);
      chk("ovf_level", 24'(level), 24'd8);
      chk("ovf_flag", 24'(ovf_flag), 24'd1);
      chk("ovf_head", m_data, 24'd1);
      chk("ovf_sat", 24'(sat_flag), 24'd0);
      drain("ovf_drain");
      chk("ovf_drained_valid", 24'(m_valid), 24'd0);
      chk("ovf_drained_data", m_data, 24'd0);
      chk("ovf_q_empty", 24'(exp_q.size()), 24'd0);
      pulse_clr();
      cyc(1);
      chk("clr_ovf", 24'(ovf_flag), 24'd0);

      // Push and pop together at full
      m_ready = 1'b0;
      for (int i = 10; i <= 17; i++) send(24'(i), 16'h4000, 24'(i), 1'b1);
      cyc(2);
      chk("full_level", 24'(level), 24'd8);
      send(24'd18, 16'h4000, 24'd18, 1'b1);
      m_ready = 1'b1;
      cyc(1);
      m_ready = 1'b0;
      chk("full_pp_level", 24'(level), 24'd8);
      chk("full_pp_ovf", 24'(ovf_flag), 24'd0);
      chk("full_pp_head", m_data, 24'd11);
      drain("full_drain");
      chk("full_q_empty", 24'(exp_q.size()), 24'd0);
      chk("full_ovf_after", 24'(ovf_flag), 24'd0);

      // Reset mid-stream at level 5 with sat set
      m_ready = 1'b0;
      for (int i = 20; i <= 23; i++) send(24'(i), 16'h4000, 24'(i), 1'b1);
      send(24'h7FFFFF, 16'h7FFF, 24'h7FFFFF, 1'b1);
      cyc(2);
      chk("mid_level", 24'(level), 24'd5);
      chk("mid_sat", 24'(sat_flag), 24'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("mrst_valid", 24'(m_valid), 24'd0);
      chk("mrst_level", 24'(level), 24'd0);
      chk("mrst_data", m_data, 24'd0);
      chk("mrst_sat", 24'(sat_flag), 24'd0);
      chk("mrst_ovf", 24'(ovf_flag), 24'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b1;
      send(24'h000777, 16'h4000, 24'h000777, 1'b1);
      chk("post_e0_valid", 24'(m_valid), 24'd0);
      cyc(1);
      chk("post_e1_valid", 24'(m_valid), 24'd1);
      chk("post_e1_data", m_data, 24'h000777);
      cyc(2);
      chk("end_q_empty", 24'(exp_q.size()), 24'd0);
      chk("end_level", 24'(level), 24'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
